// File: rtl/vreg_file_grouped.sv
// vreg_file_grouped: vector register file with element write mask and LMUL group-read sequencer
// Ports: clk/rst (sync, active-low); rd_* group-read request/beat stream on two ports;
// wr_* masked register write (one mask bit per ELEN_WIDTH element).
module vreg_file_grouped #(
  parameter int WIDTH = 512,
  parameter int ELEN_WIDTH = 64,
  parameter int REG_COUNT = 32,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  localparam int BANK_COUNT = WIDTH / ELEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_vs1,
  input  logic [ADDR_WIDTH-1:0] rd_vs2,
  input  logic [1:0]            rd_lmul,
  input  logic                  rd_stall,
  output logic                  rd_beat_valid,
  output logic [WIDTH-1:0]      rd_data1,
  output logic [WIDTH-1:0]      rd_data2,
  output logic [2:0]            rd_beat_idx,
  output logic                  rd_last,
  output logic                  rd_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [BANK_COUNT-1:0] wr_mask
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] regs [REG_COUNT];
  logic [WIDTH-1:0] merged, rdata1, rdata2, data1_n, data2_n;
  logic [ADDR_WIDTH-1:0] base1, base2, base1_n, base2_n, a1, a2, align;
  logic [1:0] lmul, lmul_n;
  logic [2:0] idx_n, top;
  logic valid_n, last_n, err_n;
  for (genvar g = 0; g < BANK_COUNT; g++) begin : g_bank
    assign merged[g*ELEN_WIDTH +: ELEN_WIDTH] = wr_mask[g] ? wr_data[g*ELEN_WIDTH +: ELEN_WIDTH]
                                                          : regs[wr_addr][g*ELEN_WIDTH +: ELEN_WIDTH];
  end
  assign rd_req_ready = state == IDLE;
  // In IDLE the read address is beat 0 of the incoming request; in BUSY it is the next beat.
  // A same-cycle write to that register is forwarded so reads see the merged value.
  always_comb begin
    top = 3'((4'd1 << lmul) - 4'd1);
    align = ADDR_WIDTH'((4'd1 << rd_lmul) - 4'd1);
    a1 = state == IDLE ? rd_vs1 : base1 + ADDR_WIDTH'(rd_beat_idx + 3'd1);
    a2 = state == IDLE ? rd_vs2 : base2 + ADDR_WIDTH'(rd_beat_idx + 3'd1);
    rdata1 = wr_en && wr_addr == a1 ? merged : regs[a1];
    rdata2 = wr_en && wr_addr == a2 ? merged : regs[a2];
  end
  always_comb begin
    state_n = state;
    base1_n = base1;
    base2_n = base2;
    lmul_n = lmul;
    idx_n = rd_beat_idx;
    valid_n = rd_beat_valid;
    last_n = rd_last;
    err_n = 1'b0;
    data1_n = rd_data1;
    data2_n = rd_data2;
    if (state == IDLE && rd_req_valid) begin
      if (((rd_vs1 | rd_vs2) & align) != '0) begin
        err_n = 1'b1;
      end else begin
        state_n = BUSY;
        base1_n = rd_vs1;
        base2_n = rd_vs2;
        lmul_n = rd_lmul;
        idx_n = 3'd0;
        valid_n = 1'b1;
        last_n = rd_lmul == 2'd0;
        data1_n = rdata1;
        data2_n = rdata2;
      end
    end else if (state == BUSY && !rd_stall) begin
      if (!rd_last) begin
        idx_n = rd_beat_idx + 3'd1;
        last_n = rd_beat_idx + 3'd1 == top;
        data1_n = rdata1;
        data2_n = rdata2;
      end else begin
        state_n = IDLE;
        valid_n = 1'b0;
        last_n = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      base1 <= '0;
      base2 <= '0;
      lmul <= '0;
      rd_beat_idx <= '0;
      rd_beat_valid <= 1'b0;
      rd_last <= 1'b0;
      rd_err <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      base1 <= base1_n;
      base2 <= base2_n;
      lmul <= lmul_n;
      rd_beat_idx <= idx_n;
      rd_beat_valid <= valid_n;
      rd_last <= last_n;
      rd_err <= err_n;
      rd_data1 <= data1_n;
      rd_data2 <= data2_n;
      if (wr_en) regs[wr_addr] <= merged;
    end
  end
endmodule

// File: tb/tb_vreg_file_grouped.sv
// tb_vreg_file_grouped: directed self-checking bench for vreg_file_grouped
module tb_vreg_file_grouped;
  localparam int W = 512;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rd_req_valid = 1'b0;
  logic rd_req_ready;
  logic [4:0] rd_vs1 = '0;
  logic [4:0] rd_vs2 = '0;
  logic [1:0] rd_lmul = '0;
  logic rd_stall = 1'b0;
  logic rd_beat_valid;
  logic [W-1:0] rd_data1, rd_data2;
  logic [2:0] rd_beat_idx;
  logic rd_last, rd_err;
  logic wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [7:0] wr_mask = '0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  vreg_file_grouped dut (
    .clk(clk), .rst(rst), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_vs1(rd_vs1), .rd_vs2(rd_vs2), .rd_lmul(rd_lmul), .rd_stall(rd_stall),
    .rd_beat_valid(rd_beat_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_beat_idx(rd_beat_idx), .rd_last(rd_last), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [4:0] a, input logic [W-1:0] d, input logic [7:0] m);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
    step();
    wr_en = 1'b0;
  endtask
  task automatic request(input logic [4:0] v1, input logic [4:0] v2, input logic [1:0] l);
    rd_req_valid = 1'b1;
    rd_vs1 = v1;
    rd_vs2 = v2;
    rd_lmul = l;
    step();
    rd_req_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    total++;
    if ({rd_beat_valid, rd_last, rd_err, rd_beat_idx, rd_req_ready} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_ctrl got v=%b l=%b e=%b i=%0d r=%b want 0 0 0 0 1",
               rd_beat_valid, rd_last, rd_err, rd_beat_idx, rd_req_ready);
    end
    total++;
    if (rd_data1 !== '0 || rd_data2 !== '0) begin
      bad++;
      $display("FAIL reset_data got d1=%h d2=%h want 0", rd_data1[63:0], rd_data2[63:0]);
    end
  endtask
  task automatic test_zero_group8(input logic [4:0] v1, input logic [4:0] v2);
    request(v1, v2, 2'd3);
    for (int b = 0; b < 8; b++) begin
      total++;
      if ({rd_beat_valid, rd_beat_idx, rd_last, rd_req_ready} !== {1'b1, 3'(b), b == 7, 1'b0}) begin
        bad++;
        $display("FAIL group8_ctrl beat %0d got v=%b i=%0d l=%b r=%b want 1 %0d %b 0",
                 b, rd_beat_valid, rd_beat_idx, rd_last, rd_req_ready, b, b == 7);
      end
      total++;
      if (rd_data1 !== '0 || rd_data2 !== '0) begin
        bad++;
        $display("FAIL group8_data beat %0d got d1=%h d2=%h want 0", b, rd_data1[63:0], rd_data2[63:0]);
      end
      step();
    end
    total++;
    if ({rd_beat_valid, rd_last, rd_req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL group8_end got v=%b l=%b r=%b want 0 0 1", rd_beat_valid, rd_last, rd_req_ready);
    end
  endtask
  task automatic test_mask();
    logic [W-1:0] exp;
    exp = {{7{64'hAAAAAAAAAAAAAAAA}}, 64'h5555555555555555};
    write(5'd5, {64{8'hAA}}, 8'hFF);
    write(5'd5, {64{8'h55}}, 8'h01);
    request(5'd5, 5'd5, 2'd0);
    total++;
    if ({rd_beat_valid, rd_beat_idx, rd_last} !== 5'b1_000_1) begin
      bad++;
      $display("FAIL mask_ctrl got v=%b i=%0d l=%b want 1 0 1", rd_beat_valid, rd_beat_idx, rd_last);
    end
    total++;
    if (rd_data1 !== exp || rd_data2 !== exp) begin
      bad++;
      $display("FAIL mask_data got d1=%h want %h", rd_data1[127:0], exp[127:0]);
    end
    step();
    write(5'd5, '0, 8'h00);
    request(5'd5, 5'd0, 2'd0);
    total++;
    if (rd_data1 !== exp || rd_data2 !== '0) begin
      bad++;
      $display("FAIL mask_zero got d1=%h d2=%h want %h 0", rd_data1[127:0], rd_data2[63:0], exp[127:0]);
    end
    step();
  endtask
  task automatic test_write_first();
    write(5'd8, {64{8'h33}}, 8'hFF);
    write(5'd9, {64{8'h11}}, 8'hFF);
    request(5'd8, 5'd8, 2'd1);
    wr_en = 1'b1;
    wr_addr = 5'd9;
    wr_data = {64{8'h22}};
    wr_mask = 8'hFF;
    total++;
    if ({rd_beat_valid, rd_beat_idx, rd_last} !== 5'b1_000_0 || rd_data1 !== {64{8'h33}}) begin
      bad++;
      $display("FAIL wf_beat0 got v=%b i=%0d l=%b d1=%h want 1 0 0 33..",
               rd_beat_valid, rd_beat_idx, rd_last, rd_data1[63:0]);
    end
    step();
    wr_en = 1'b0;
    total++;
    if ({rd_beat_valid, rd_beat_idx, rd_last} !== 5'b1_001_1) begin
      bad++;
      $display("FAIL wf_beat1_ctrl got v=%b i=%0d l=%b want 1 1 1", rd_beat_valid, rd_beat_idx, rd_last);
    end
    total++;
    if (rd_data1 !== {64{8'h22}} || rd_data2 !== {64{8'h22}}) begin
      bad++;
      $display("FAIL wf_beat1_data got d1=%h d2=%h want 22..", rd_data1[63:0], rd_data2[63:0]);
    end
    step();
    total++;
    if ({rd_beat_valid, rd_req_ready} !== 2'b01 || rd_data1 !== {64{8'h22}}) begin
      bad++;
      $display("FAIL wf_end got v=%b r=%b d1=%h want 0 1 22..", rd_beat_valid, rd_req_ready, rd_data1[63:0]);
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] seq;
    rd_req_valid = 1'b1;
    rd_vs1 = 5'd9;
    rd_vs2 = 5'd8;
    rd_lmul = 2'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      seq[2-k] = rd_beat_valid;
    end
    rd_req_valid = 1'b0;
    total++;
    if (seq !== 3'b101 || rd_data2 !== {64{8'h33}}) begin
      bad++;
      $display("FAIL back_to_back got valid seq=%b d2=%h want 101 33..", seq, rd_data2[63:0]);
    end
    step();
  endtask
  task automatic test_misaligned(input logic [4:0] v1, input logic [4:0] v2, input logic [1:0] l);
    request(v1, v2, l);
    total++;
    if ({rd_err, rd_beat_valid, rd_req_ready} !== 3'b101) begin
      bad++;
      $display("FAIL misalign_pulse vs1=%0d vs2=%0d got e=%b v=%b r=%b want 1 0 1",
               v1, v2, rd_err, rd_beat_valid, rd_req_ready);
    end
    step();
    total++;
    if ({rd_err, rd_beat_valid, rd_req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL misalign_after got e=%b v=%b r=%b want 0 0 1", rd_err, rd_beat_valid, rd_req_ready);
    end
  endtask
  task automatic test_stall();
    int exp_idx [7] = '{0, 1, 1, 1, 1, 2, 3};
    logic [7:0] bt;
    for (int i = 0; i < 4; i++) write(5'(12 + i), {64{8'hC0 + 8'(i)}}, 8'hFF);
    request(5'd12, 5'd12, 2'd2);
    for (int k = 0; k < 7; k++) begin
      bt = 8'hC0 + 8'(exp_idx[k]);
      total++;
      if ({rd_beat_valid, rd_beat_idx, rd_last} !== {1'b1, 3'(exp_idx[k]), k == 6} || rd_data1 !== {64{bt}}) begin
        bad++;
        $display("FAIL stall cycle %0d got v=%b i=%0d l=%b d1=%h want 1 %0d %b %h",
                 k, rd_beat_valid, rd_beat_idx, rd_last, rd_data1[63:0], exp_idx[k], k == 6, bt);
      end
      rd_stall = k >= 1 && k <= 3;
      step();
    end
    total++;
    if ({rd_beat_valid, rd_req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stall_end got v=%b r=%b want 0 1", rd_beat_valid, rd_req_ready);
    end
  endtask
  task automatic test_reset_mid();
    write(5'd18, {64{8'h77}}, 8'hFF);
    request(5'd16, 5'd24, 2'd3);
    step();
    step();
    total++;
    if (rd_beat_idx !== 3'd2 || rd_data1 !== {64{8'h77}}) begin
      bad++;
      $display("FAIL rst_mid_pre got i=%0d d1=%h want 2 77..", rd_beat_idx, rd_data1[63:0]);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    total++;
    if ({rd_beat_valid, rd_last, rd_beat_idx, rd_req_ready} !== 6'b00_000_1 || rd_data1 !== '0) begin
      bad++;
      $display("FAIL rst_mid got v=%b l=%b i=%0d r=%b want 0 0 0 1", rd_beat_valid, rd_last, rd_beat_idx, rd_req_ready);
    end
    step();
    total++;
    if (rd_beat_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_abandon got v=%b want 0", rd_beat_valid);
    end
    test_zero_group8(5'd0, 5'd8);
    test_zero_group8(5'd16, 5'd24);
  endtask
  initial begin
    test_reset();
    test_zero_group8(5'd0, 5'd8);
    test_mask();
    test_write_first();
    test_back_to_back();
    test_misaligned(5'd6, 5'd0, 2'd2);
    test_misaligned(5'd0, 5'd3, 2'd1);
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
